// File: rtl/fnd_display_ctrl_if.sv
// Bundle between the value source and the 7-segment display controller.
//   count    : binary value to show (clamped to 9999 by the controller)
//   blank_lz : leading-zero blanking enable
//   dp_en    : tenths decimal point enable (lights dp on digit 1)
//   fnd_com  : digit enables, active-low, bit 0 = ones digit
//   fnd_font : segments, active-low, {dp,g,f,e,d,c,b,a}
interface fnd_display_ctrl_if;
  localparam int unsigned CNT_W  = 14;
  localparam int unsigned COM_W  = 4;
  localparam int unsigned FONT_W = 8;

  logic [CNT_W-1:0]  count;
  logic              blank_lz;
  logic              dp_en;
  logic [COM_W-1:0]  fnd_com;
  logic [FONT_W-1:0] fnd_font;

  modport master (output count, output blank_lz, output dp_en,
                  input fnd_com, input fnd_font);
  modport slave  (input count, input blank_lz, input dp_en,
                  output fnd_com, output fnd_font);
endinterface

// File: rtl/fnd_display_ctrl.sv
// 4-digit common-anode FND driver: continuous double-dabble conversion of a
// 14-bit value into BCD, atomic latch into a display register, and a
// prescaled scan that time-multiplexes the digits.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of fnd_display_ctrl_if (count/options in,
//                fnd_com/fnd_font out, both outputs registered)
module fnd_display_ctrl #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1_000
) (
  input  logic              clk,
  input  logic              reset,
  fnd_display_ctrl_if.slave bus
);

  localparam int unsigned SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned PRE_W    = $clog2(SCAN_DIV);
  localparam int unsigned BIN_W    = 14;
  localparam int unsigned BCD_W    = 16;
  localparam int unsigned CNT_W    = 4;
  localparam logic [BIN_W-1:0] MAX_VAL  = 14'd9999;
  localparam logic [CNT_W-1:0] LAST_BIT = 4'd13;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCD_W-1:0]   digit_reg, digit_nxt;
  logic [PRE_W-1:0]   pre_q;
  logic [1:0]         idx_q;
  logic               scan_tick_c;
  logic [3:0]         com_q, com_c;
  logic [7:0]         font_q, font_c;
  logic [3:0]         digit_sel;
  logic               lead_zero;
  logic [3:1]         upper_zero;

  // Conversion state register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digit_reg <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      digit_reg <= digit_nxt;
    end
  end

  // Conversion next-state: IDLE samples, 14 SHIFTs, UPDATE latches all digits at once
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    digit_nxt = digit_reg;
    adj       = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        bin_d     = (bus.count > MAX_VAL) ? MAX_VAL : bus.count;
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        bit_cnt_d      = bit_cnt_q + 4'd1;
        if (bit_cnt_q == LAST_BIT) state_d = UPDATE;
      end
      UPDATE: begin
        digit_nxt = bcd_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_tick_c = (pre_q == PRE_W'(SCAN_DIV - 1));

  // Scan prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (scan_tick_c) begin
      pre_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  function automatic logic [7:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Digit select, leading-zero detection and font decode for the active digit
  always_comb begin
    upper_zero[3] = (digit_reg[15:12] == 4'd0);
    upper_zero[2] = upper_zero[3] && (digit_reg[11:8] == 4'd0);
    upper_zero[1] = upper_zero[2] && (digit_reg[7:4] == 4'd0);
    digit_sel = digit_reg[3:0];
    lead_zero = 1'b0;
    case (idx_q)
      2'd1: begin
        digit_sel = digit_reg[7:4];
        lead_zero = upper_zero[1] && !bus.dp_en;
      end
      2'd2: begin
        digit_sel = digit_reg[11:8];
        lead_zero = upper_zero[2];
      end
      2'd3: begin
        digit_sel = digit_reg[15:12];
        lead_zero = upper_zero[3];
      end
      default: ;
    endcase
    font_c = (bus.blank_lz && lead_zero) ? 8'hFF : seg_font(digit_sel);
    if (bus.dp_en && (idx_q == 2'd1)) font_c[7] = 1'b0;
    com_c = ~(4'b0001 << idx_q);
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      com_q  <= 4'b1111;
      font_q <= 8'hFF;
    end else begin
      com_q  <= com_c;
      font_q <= font_c;
    end
  end

  assign bus.fnd_com  = com_q;
  assign bus.fnd_font = font_q;

endmodule

// File: doc/fnd_display_ctrl.md
# fnd_display_ctrl

Drives a 4-digit, common-anode 7-segment display (FND) from a 14-bit binary value in the range 0–9999. It is the display-side consumer of the up/down counter's `count` output.

- A sequential double-dabble engine converts the binary value to BCD.
- The converted digits are latched atomically into a display register.
- A prescaled scan counter time-multiplexes the four digits.
- Options: leading-zero blanking and a tenths decimal point.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: input clock frequency in Hz.
- `SCAN_HZ`, default 1_000: per-digit scan rate in Hz. The derived value `SCAN_DIV = CLK_FREQ/SCAN_HZ` must be ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `count`  in  14: binary value to display. Values above 9999 are clamped to 9999.
- `blank_lz`  in  1: when 1, leading zeros are blanked.
- `dp_en`  in  1: when 1, the decimal point is lit on digit 1 and digit 1 is never blanked.
- `fnd_com`  out  4: digit enables, active-low. Bit 0 is the ones digit, bit 3 the thousands digit.
- `fnd_font`  out  8: segment lines, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
**Conversion FSM**, states IDLE, SHIFT, UPDATE:
- **IDLE**, 1 cycle:
  - Load `bin` with `min(count, 9999)`.
  - Clear the 16-bit `bcd` register.
  - Set `bit_cnt` to 0.
  - Next state: SHIFT.
- **SHIFT**, exactly 14 cycles:
  - Each cycle, add 3 to every BCD nibble ≥ 5.
  - Then shift `{bcd, bin}` left by 1.
  - Increment `bit_cnt`; go to UPDATE after `bit_cnt == 13`.
- **UPDATE**, 1 cycle:
  - Load `digit_reg[15:0]` from `bcd` in one step.
  - Next state: IDLE.
- The conversion period is a fixed 16 cycles and runs continuously, with no start/done handshake.
- `count` is sampled only in IDLE. Changes during SHIFT or UPDATE are ignored until the next IDLE.
- `digit_reg` is never partially updated, so the display never shows a mix of old and new digits.

**Scan:**
- A prescaler counts 0..SCAN_DIV-1 and asserts a 1-cycle `scan_tick` at SCAN_DIV-1, then wraps to 0.
- On `scan_tick`, the 2-bit `idx` increments, wrapping 3 → 0.
- Digit order is 0 → 1 → 2 → 3 → 0.

**Output decode** (registered; takes `idx` and `digit_reg`):
- `fnd_com = ~(4'b0001 << idx)`.
- Font encoding for digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- When `dp_en=1` and `idx==1`, bit 7 is cleared, which lights the decimal point.
- Blanking: digit i (i = 1..3) outputs FF when all of the following hold:
  - `blank_lz=1`;
  - digits i..3 of `digit_reg` are all 0;
  - NOT (`dp_en=1` and i==1).
- Digit 0 is never blanked, so a value of 0 shows "0".
- Nibbles above 9 cannot occur. If one did, the decoder would output FF (defensive default).

**Reset** (asynchronous, takes effect immediately including mid-conversion or mid-scan):
- FSM returns to IDLE.
- `bin`, `bcd`, `bit_cnt`, `digit_reg`, prescaler and `idx` are cleared to 0.
- `fnd_com` = 4'b1111 (all digits off).
- `fnd_font` = 8'hFF (all segments off).

## Timing
- **First outputs after reset release:**
  - The edge after release registers `fnd_com=4'b1110` and `fnd_font=8'hC0` (digit_reg=0), or 8'h40 if `dp_en` with digit 1.
  - The first UPDATE occurs at the 16th edge after release.
- **Conversion latency:** `count` sampled at IDLE edge k reaches `digit_reg` at edge k+15. The worst case from a `count` change to `digit_reg` is 31 cycles.
- **Output latency:** `fnd_com`/`fnd_font` follow `idx` or `digit_reg` changes by exactly 1 cycle.
- **Scan timing:**
  - Each digit stays active for SCAN_DIV cycles.
  - The full refresh period is 4·SCAN_DIV cycles: 250 Hz frame at the defaults.
  - `fnd_com` always has exactly one bit low outside reset, so there is no all-on or overlap glitch.
- **Combined case:** if `scan_tick` coincides with UPDATE, the next registered output uses the new `idx` and the new `digit_reg` together.

## Test plan
Simulation parameters: CLK_FREQ=1000, SCAN_HZ=100, giving SCAN_DIV=10.

1. **Reset:** assert `reset` mid-scan → `fnd_com`=1111 and `fnd_font`=FF asynchronously. Release with `count`=0 and `blank_lz`=0 → next edge gives com 1110 / font C0. Subsequent digits show C0 on 1101, 1011 and 0111, each held 10 cycles.
2. **Normal value:** `count`=1234, `blank_lz`=0, after 32 cycles → expect these com/font pairs, each held 10 cycles, then repeating:
   - 1110 / 99
   - 1101 / B0
   - 1011 / A4
   - 0111 / F9
3. **Leading-zero blanking:** `count`=7, `blank_lz`=1 → com 1110 / font F8. Digits 1–3 output FF while their com bit is low.
4. **Clamping:** `count`=9999 and then `count`=16383 → all four digits show 90 in both cases. `count`=10000 also shows 9999.
5. **Mid-conversion change:** set `count`=1234, then change to 5678 on the 5th SHIFT cycle →
   - `digit_reg` holds 1234 at the next UPDATE;
   - it holds 5678 within 31 cycles of the change;
   - no intermediate digit pattern (e.g. 1278) ever appears on `fnd_font`.
6. **Decimal point:** `dp_en`=1, `blank_lz`=1, `count`=5 →
   - digit 0 = 92;
   - digit 1 = 40 ("0.");
   - digits 2 and 3 = FF.
